// File: rtl/scpu_mem_pkg.sv
// Shared constants and state encoding for the two-port memory arbiter.
package scpu_mem_pkg;

  localparam int unsigned DefAddrW    = 16;
  localparam int unsigned DefDataW    = 8;
  localparam int unsigned DefMemDepth = 1024;

  localparam logic P_FETCH = 1'b0;
  localparam logic P_LS    = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StAck
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports and the memory pins seen by mem_arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = scpu_mem_pkg::DefAddrW,
  parameter int unsigned DATA_W = scpu_mem_pkg::DefDataW
);

  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_ack;
  logic              r0_err;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_ack;
  logic              r1_err;
  logic [DATA_W-1:0] r1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ce;
  logic              mem_w;
  logic              mem_r;
  logic              mem_oe;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_rdata,
    output r0_ack, r0_err, r0_rdata,
    output r1_ack, r1_err, r1_rdata,
    output mem_addr, mem_wdata, mem_ce, mem_w, mem_r, mem_oe, busy
  );

  // Core + memory side.
  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_rdata,
    input  r0_ack, r0_err, r0_rdata,
    input  r1_ack, r1_err, r1_rdata,
    input  mem_addr, mem_wdata, mem_ce, mem_w, mem_r, mem_oe, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way grant: round-robin or fixed priority on ties.
module rr_arb2
  import scpu_mem_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       grant
);

  always_comb begin
    valid = |req;
    grant = P_FETCH;
    case (req)
      2'b01:   grant = P_FETCH;
      2'b10:   grant = P_LS;
      2'b11:   grant = RR ? ~last_grant : P_FETCH;
      default: grant = P_FETCH;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port sequencer for the single-port byte memory: IDLE -> ISSUE -> CAPTURE -> ACK.
module mem_arbiter
  import scpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned MEM_DEPTH = DefMemDepth,
  parameter bit          RR        = 1'b1
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  logic              winner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              last_grant_q;

  logic arb_valid;
  logic arb_grant;
  logic addr_err;

  rr_arb2 #(
    .RR (RR)
  ) u_rr_arb2 (
    .req        ({bus.r1_req, bus.r0_req}),
    .last_grant (last_grant_q),
    .valid      (arb_valid),
    .grant      (arb_grant)
  );

  assign addr_err = 32'(addr_q) >= 32'(MEM_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (arb_valid) state_d = StIssue;
      StIssue:   state_d = StCapture;
      StCapture: state_d = StAck;
      StAck:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      winner_q     <= P_FETCH;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      last_grant_q <= P_LS;
    end else begin
      if (state_q == StIdle && arb_valid) begin
        winner_q <= arb_grant;
        we_q     <= arb_grant ? bus.r1_we    : bus.r0_we;
        addr_q   <= arb_grant ? bus.r1_addr  : bus.r0_addr;
        wdata_q  <= arb_grant ? bus.r1_wdata : bus.r0_wdata;
      end
      // mem_rdata may float outside CAPTURE, so it is only sampled on a real read.
      if (state_q == StCapture) begin
        rdata_q <= (!we_q && !addr_err) ? bus.mem_rdata : '0;
      end
      if (state_q == StAck) last_grant_q <= winner_q;
    end
  end

  assign bus.mem_oe = ~rst;

  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.mem_ce    = 1'b0;
    bus.mem_w     = 1'b0;
    bus.mem_r     = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.r0_ack    = 1'b0;
    bus.r0_err    = 1'b0;
    bus.r0_rdata  = '0;
    bus.r1_ack    = 1'b0;
    bus.r1_err    = 1'b0;
    bus.r1_rdata  = '0;
    if (!rst && state_q != StIdle) begin
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      unique case (state_q)
        StIssue: begin
          bus.mem_ce = ~addr_err;
          bus.mem_w  = ~addr_err & we_q;
          bus.mem_r  = ~addr_err & ~we_q;
        end
        StAck: begin
          if (winner_q == P_LS) begin
            bus.r1_ack   = 1'b1;
            bus.r1_err   = addr_err;
            bus.r1_rdata = rdata_q;
          end else begin
            bus.r0_ack   = 1'b1;
            bus.r0_err   = addr_err;
            bus.r0_rdata = rdata_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a registered-read byte memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus_a ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus_b ();

  mem_arbiter #(
    .ADDR_W    (16),
    .DATA_W    (8),
    .MEM_DEPTH (1024),
    .RR        (1'b1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mem_arbiter #(
    .ADDR_W    (16),
    .DATA_W    (8),
    .MEM_DEPTH (1024),
    .RR        (1'b0)
  ) u_dut_fixed (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Memory contents after reset: byte i holds i ^ 0xA5.
  logic [7:0] mem_a [1024];
  logic [7:0] mem_rdata_q;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= 8'(i) ^ 8'hA5;
      mem_rdata_q <= '0;
    end else if (bus_a.mem_ce) begin
      if (bus_a.mem_w) mem_a[bus_a.mem_addr[9:0]] <= bus_a.mem_wdata;
      if (bus_a.mem_r) mem_rdata_q <= mem_a[bus_a.mem_addr[9:0]];
    end
  end
  assign bus_a.mem_rdata = mem_rdata_q;
  assign bus_b.mem_rdata = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("oe_in_rst", 32'(bus_a.mem_oe), 32'd0);
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_ack(input bit port, input int budget, output int n);
    n = -1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if ((port ? bus_a.r1_ack : bus_a.r0_ack) === 1'b1) begin
        n = c;
        break;
      end
    end
  endtask

  int n, t0, t1, idle_cnt, b0, b1, seq_n, ce_seen;
  int seq [4];

  initial begin
    bus_a.r0_req = 0; bus_a.r0_we = 0; bus_a.r0_addr = '0; bus_a.r0_wdata = '0;
    bus_a.r1_req = 0; bus_a.r1_we = 0; bus_a.r1_addr = '0; bus_a.r1_wdata = '0;
    bus_b.r0_req = 0; bus_b.r0_we = 0; bus_b.r0_addr = '0; bus_b.r0_wdata = '0;
    bus_b.r1_req = 0; bus_b.r1_we = 0; bus_b.r1_addr = '0; bus_b.r1_wdata = '0;

    do_reset();
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_ce", 32'(bus_a.mem_ce), 32'd0);
    check("rst_addr", 32'(bus_a.mem_addr), 32'd0);
    check("rst_ack", 32'({bus_a.r1_ack, bus_a.r0_ack}), 32'd0);
    check("rst_oe", 32'(bus_a.mem_oe), 32'd1);

    // 1: write 0x3C to 0x0010, then read it back.
    bus_a.r0_req = 1; bus_a.r0_we = 1; bus_a.r0_addr = 16'h0010; bus_a.r0_wdata = 8'h3C;
    tick();
    check("t1_ce_w", 32'({bus_a.mem_ce, bus_a.mem_w, bus_a.mem_r}), 32'b110);
    check("t1_addr", 32'(bus_a.mem_addr), 32'h10);
    check("t1_wdata", 32'(bus_a.mem_wdata), 32'h3C);
    tick();
    check("t1_cap_ce", 32'(bus_a.mem_ce), 32'd0);
    tick();
    check("t1_wack", 32'({bus_a.r0_ack, bus_a.r0_err}), 32'b10);
    check("t1_wrdata", 32'(bus_a.r0_rdata), 32'h00);
    bus_a.r0_we = 0;
    wait_ack(1'b0, 8, n);
    check("t1_rd_lat", 32'(n), 32'd4);
    check("t1_rdata", 32'({bus_a.r0_err, bus_a.r0_rdata}), 32'h03C);
    bus_a.r0_req = 0;
    tick();
    check("t1_idle", 32'(bus_a.busy), 32'd0);

    // 2: simultaneous reads after reset, r0 first.
    do_reset();
    bus_a.r0_req = 1; bus_a.r0_addr = 16'h0020;
    bus_a.r1_req = 1; bus_a.r1_addr = 16'h0031;
    t0 = -1; t1 = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus_a.r0_ack) begin
        t0 = c;
        check("t2_r0_rdata", 32'(bus_a.r0_rdata), 32'h85);
        bus_a.r0_req = 0;
      end
      if (bus_a.r1_ack) begin
        t1 = c;
        check("t2_r1_rdata", 32'(bus_a.r1_rdata), 32'h94);
        bus_a.r1_req = 0;
      end
    end
    check("t2_r0_cycle", 32'(t0), 32'd3);
    check("t2_r1_cycle", 32'(t1), 32'd7);

    // 3: both held; RR alternates, fixed priority starves port 1.
    do_reset();
    bus_a.r0_req = 1; bus_a.r0_addr = 16'h0001;
    bus_a.r1_req = 1; bus_a.r1_addr = 16'h0002;
    bus_b.r0_req = 1; bus_b.r0_addr = 16'h0001;
    bus_b.r1_req = 1; bus_b.r1_addr = 16'h0002;
    seq_n = 0; b0 = 0; b1 = 0;
    for (int k = 0; k < 4; k++) seq[k] = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus_a.r0_ack) begin if (seq_n < 4) seq[seq_n] = 0; seq_n++; end
      if (bus_a.r1_ack) begin if (seq_n < 4) seq[seq_n] = 1; seq_n++; end
      b0 += int'(bus_b.r0_ack);
      b1 += int'(bus_b.r1_ack);
    end
    check("t3_g0", 32'(seq[0]), 32'd0);
    check("t3_g1", 32'(seq[1]), 32'd1);
    check("t3_g2", 32'(seq[2]), 32'd0);
    check("t3_g3", 32'(seq[3]), 32'd1);
    check("t3_fixed_r0", 32'(b0), 32'd5);
    check("t3_fixed_r1", 32'(b1), 32'd0);
    bus_a.r0_req = 0; bus_a.r1_req = 0; bus_b.r0_req = 0; bus_b.r1_req = 0;
    for (int c = 0; c < 8 && (bus_a.busy || bus_b.busy); c++) tick();
    check("t3_drain", 32'({bus_a.busy, bus_b.busy}), 32'd0);

    // 4: out-of-range read on port 1.
    bus_a.r1_req = 1; bus_a.r1_we = 0; bus_a.r1_addr = 16'h0400;
    ce_seen = 0; n = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      ce_seen |= int'(bus_a.mem_ce);
      if (bus_a.r1_ack) begin
        n = c;
        check("t4_err", 32'(bus_a.r1_err), 32'd1);
        check("t4_rdata", 32'(bus_a.r1_rdata), 32'd0);
        break;
      end
    end
    bus_a.r1_req = 0;
    check("t4_lat", 32'(n), 32'd3);
    check("t4_no_ce", 32'(ce_seen), 32'd0);
    tick();

    // 5: reset during CAPTURE of a read; held req acts as the reissue.
    bus_a.r0_req = 1; bus_a.r0_we = 0; bus_a.r0_addr = 16'h0050;
    tick();
    tick();
    check("t5_in_cap", 32'({bus_a.busy, bus_a.mem_ce}), 32'b10);
    rst = 1'b1;
    tick();
    check("t5_rst_ack", 32'(bus_a.r0_ack), 32'd0);
    rst = 1'b0;
    #1;
    check("t5_busy", 32'(bus_a.busy), 32'd0);
    check("t5_addr", 32'(bus_a.mem_addr), 32'd0);
    check("t5_oe", 32'(bus_a.mem_oe), 32'd1);
    wait_ack(1'b0, 8, n);
    check("t5_relat", 32'(n), 32'd3);
    check("t5_rdata", 32'(bus_a.r0_rdata), 32'hF5);
    bus_a.r0_req = 0;
    tick();

    // 6: r1 write in flight, r0 read of the same byte queues behind it.
    do_reset();
    bus_a.r1_req = 1; bus_a.r1_we = 1; bus_a.r1_addr = 16'h0060; bus_a.r1_wdata = 8'h77;
    t0 = -1; t1 = -1; idle_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin
        bus_a.r0_req = 1; bus_a.r0_we = 0; bus_a.r0_addr = 16'h0060;
      end
      if (!bus_a.busy) idle_cnt++;
      if (bus_a.r1_ack) begin
        t1 = c;
        bus_a.r1_req = 0;
      end
      if (bus_a.r0_ack) begin
        t0 = c;
        check("t6_rdata", 32'(bus_a.r0_rdata), 32'h77);
        bus_a.r0_req = 0;
        break;
      end
    end
    check("t6_r1_cycle", 32'(t1), 32'd3);
    check("t6_gap", 32'(t0 - t1), 32'd4);
    check("t6_idle_cycles", 32'(idle_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
